// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 slave with an internal byte-strobed memory and independent write/read burst FSMs.
module axi4_mem_responder #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LG     = $clog2(STRB_W);
  localparam int WORDS  = MEM_BYTES / STRB_W;
  localparam int IW     = $clog2(WORDS);
  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wst_t;
  typedef enum logic {RIDLE, RDATA} rs_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [7:0]        cnt;
    logic              dec;
    logic              slv;
  } ctx_t;

  logic [DATA_W-1:0] mem [WORDS];
  wst_t wst_q, wst_d;
  rs_t rs_q, rs_d;
  ctx_t w_q, w_d, r_q, r_d;
  logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                            input logic [7:0] len, input logic [1:0] bu);
    logic [ADDR_W-1:0] inc, wb;
    inc = ADDR_W'(1) << sz;
    wb  = (ADDR_W'(len) + ADDR_W'(1)) * inc;
    return bu == 2'b00 ? a : bu == 2'b10 ? (a & ~(wb - ADDR_W'(1))) | ((a + inc) & (wb - ADDR_W'(1))) : a + inc;
  endfunction

  function automatic logic herr(input logic [2:0] sz, input logic [7:0] len, input logic [1:0] bu);
    return sz > 3'(LG) || bu == 2'b11 ||
           (bu == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
  endfunction

  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return a >= ADDR_W'(MEM_BYTES);
  endfunction

  function automatic logic [IW-1:0] idx(input logic [ADDR_W-1:0] a);
    return a[LG +: IW];
  endfunction

  logic aw_hs, w_hs, w_oor, w_lastb, ar_hs, r_hs, rd_oor, rd_he;
  logic [ADDR_W-1:0] rd_a;
  assign aw_hs   = s_awvalid & awready_q;
  assign w_hs    = s_wvalid & wready_q;
  assign w_oor   = oor(w_q.addr);
  assign w_lastb = w_q.cnt == w_q.len;
  assign ar_hs   = s_arvalid & arready_q;
  assign r_hs    = rvalid_q & s_rready;
  assign rd_a    = ar_hs ? s_araddr : r_q.addr;
  assign rd_oor  = oor(rd_a);
  assign rd_he   = ar_hs ? herr(s_arsize, s_arlen, s_arburst) : r_q.slv;

  always_comb begin
    wst_d   = wst_q;
    w_d     = w_q;
    bresp_d = bresp_q;
    if (aw_hs) begin
      w_d   = '{id: s_awid, addr: s_awaddr, len: s_awlen, size: s_awsize, burst: s_awburst,
                cnt: '0, dec: 1'b0, slv: herr(s_awsize, s_awlen, s_awburst)};
      wst_d = WDATA;
    end
    if (w_hs) begin
      w_d.addr = nxt(w_q.addr, w_q.size, w_q.len, w_q.burst);
      w_d.cnt  = w_q.cnt + 8'd1;
      w_d.dec  = w_q.dec | w_oor;
      w_d.slv  = w_q.slv | (s_wlast != w_lastb);
      wst_d    = w_lastb ? WRESP : wst_q;
      bresp_d  = w_lastb ? (w_d.dec ? 2'b11 : w_d.slv ? 2'b10 : 2'b00) : bresp_q;
    end
    if (bvalid_q && s_bready) wst_d = WIDLE;
  end

  // beat data is taken from the pre-write array word, so same-cycle reads see old data
  always_comb begin
    rs_d     = rs_q;
    r_d      = r_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    if (ar_hs) begin
      r_d      = '{id: s_arid, addr: nxt(s_araddr, s_arsize, s_arlen, s_arburst), len: s_arlen,
                   size: s_arsize, burst: s_arburst, cnt: '0, dec: 1'b0, slv: rd_he};
      rs_d     = RDATA;
      rvalid_d = 1'b1;
      rdata_d  = rd_oor ? '0 : mem[idx(rd_a)];
      rresp_d  = rd_oor ? 2'b11 : rd_he ? 2'b10 : 2'b00;
      rlast_d  = s_arlen == 8'd0;
    end else if (r_hs && rlast_q) begin
      rs_d     = RIDLE;
      rvalid_d = 1'b0;
    end else if (r_hs) begin
      r_d.addr = nxt(r_q.addr, r_q.size, r_q.len, r_q.burst);
      r_d.cnt  = r_q.cnt + 8'd1;
      rdata_d  = rd_oor ? '0 : mem[idx(rd_a)];
      rresp_d  = rd_oor ? 2'b11 : rd_he ? 2'b10 : 2'b00;
      rlast_d  = r_q.cnt + 8'd1 == r_q.len;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wst_q     <= WIDLE;
      rs_q      <= RIDLE;
      w_q       <= '0;
      r_q       <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      wst_q     <= wst_d;
      rs_q      <= rs_d;
      w_q       <= w_d;
      r_q       <= r_d;
      awready_q <= wst_d == WIDLE;
      wready_q  <= wst_d == WDATA;
      bvalid_q  <= wst_d == WRESP;
      bresp_q   <= bresp_d;
      arready_q <= rs_d == RIDLE;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  always_ff @(posedge aclk)
    if (!reset && w_hs && !w_oor)
      for (int i = 0; i < STRB_W; i++)
        if (s_wstrb[i]) mem[idx(w_q.addr)][8*i +: 8] <= s_wdata[8*i +: 8];

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bid     = w_q.id;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rid     = r_q.id;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign s_rlast   = rlast_q;
endmodule
